mbldcm_avmm_regfile: RTL and testbench
======================================

Name: mbldcm_avmm_regfile

Overview:
- Multi-channel successor to the single-motor Avalon-MM slave interface of the BLDC controller.
- Gives NUM_CH motor cores a register bank each: frequency target, phase, control and status.
- Reads are registered with a fixed 1-cycle latency and a readdatavalid strobe. Each frequency update is a handshake with the core, and a pending flag is kept until the core acknowledges it.
- Sits between the HPS/Qsys Avalon-MM bridge and the per-channel mBldcm cores. It also drives one level interrupt formed from the sticky stop events.

Parameters:
- NUM_CH, 2: number of motor channels, 1..4.
- CH_AW, 1: channel-select address bits. Must satisfy 2**CH_AW >= NUM_CH.
- FREQ_W, 32: frequency target width, 1..32. Upper read bits are zero.
- PHASE_W, 4: phase vector width, 1..8.

Ports:
- iClock  in  1  system clock.
- iReset_n  in  1  synchronous active-low reset.
- iAddr  in  CH_AW+2  word address: {channel, word[1:0]}.
- iRead  in  1  read strobe, single cycle.
- iWrite  in  1  write strobe, single cycle.
- iWdata  in  32  write data.
- oRdata  out  32  registered read data.
- oReadDataValid  out  1  read data valid, one cycle after iRead.
- oResp  out  2  read response, qualified by oReadDataValid: 00 OKAY, 11 DECODEERROR.
- oIrq  out  1  level interrupt.
- iFreqAck  in  NUM_CH  per-channel 1-cycle pulse: the core has adopted its new target.
- iStop  in  NUM_CH  per-channel motor-stopped level.
- iPhase  in  NUM_CH*PHASE_W  live phase, channel c at bits [c*PHASE_W +: PHASE_W].
- oFreqTarget  out  NUM_CH*FREQ_W  registered targets.
- oFreqUpdate  out  NUM_CH  1-cycle update strobe.
- oPhaseUpdate  out  NUM_CH*PHASE_W  registered phase commands.
- oPhaseLatch  out  NUM_CH  1-cycle phase latch strobe.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low on iReset_n, sampled at the rising edge of iClock. It is applied to every flop.
- Reset values: all outputs 0 and all registers 0, except stop_q, which resets to all-ones.
- Channel decode: ch = iAddr[CH_AW+1:2]. A channel is valid when ch < NUM_CH.
- Word map per channel:
  - 0 FREQ: RW, FREQ_W bits.
  - 1 PHASE: reads live iPhase; writes issue a phase command.
  - 2 CTRL: RW, bit0 ENABLE, bit1 IRQ_EN, other bits read 0.
  - 3 STATUS: bit0 iStop (live), bit1 UPDATE_PENDING, bit2 STOP_EVENT (sticky, write-1-to-clear), other bits read 0. STATUS writes affect only bit2.
- Read path:
  - iRead in cycle N gives oReadDataValid=1 in cycle N+1 with oRdata and oResp. Both hold until the next read.
  - A read of an invalid channel returns 0xFFFFFFFF with oResp=11.
- Write path:
  - Writes to an invalid channel are ignored.
  - iRead and iWrite in the same cycle: both execute, and the read returns the pre-write value.
- FREQ write:
  - oFreqTarget[ch] takes wdata[FREQ_W-1:0] at N+1.
  - oFreqUpdate[ch] pulses at N+1, but only if CTRL.ENABLE=1.
  - PENDING is set at N+1 whenever the strobe fires.
  - A FREQ write while ENABLE=0 updates the register with no strobe. Setting ENABLE 0->1 later does not retro-strobe.
- PENDING clear:
  - iFreqAck[ch] clears PENDING.
  - iFreqAck in the same cycle as a FREQ write to that channel: set wins.
  - iFreqAck while PENDING=0 is ignored.
- PHASE write: oPhaseUpdate[ch] takes wdata[PHASE_W-1:0] and oPhaseLatch[ch] pulses at N+1. ENABLE does not gate phase writes.
- Stop events:
  - stop_q registers iStop. A rising edge (iStop & ~stop_q) sets STOP_EVENT.
  - Stop already high when reset is released produces no event.
  - An edge in the same cycle as a W1C clear: set wins.
- Interrupt: oIrq is registered and equals OR over channels of (STOP_EVENT & IRQ_EN). It is visible one cycle after the event bit changes.
- Reset mid-operation: clears pending strobes and PENDING in the same edge. No strobe is emitted after reset.

Decomposition:
- Package mbldcm_pkg holds:
  - word offsets: FREQ=0, PHASE=1, CTRL=2, STATUS=3;
  - response codes RESP_OKAY=2'b00 and RESP_DECERR=2'b11;
  - CTRL and STATUS bit indices;
  - DECERR_DATA=32'hFFFFFFFF.
- Sub-module mbldcm_ch_regs, instantiated NUM_CH times in a generate loop, holds one channel's registers, strobes, PENDING, stop edge detect and STOP_EVENT.
- The top holds address decode, the read mux, read pipeline registers and the IRQ OR-reduce.

Test Plan:
- Reset, then read ch0 and ch1 STATUS -> rdata 0 (iStop low), valid exactly 1 cycle after iRead, resp 00, all strobes 0.
- Write ch1 CTRL=1, write ch1 FREQ=0x00001234 -> next cycle oFreqTarget[ch1]=0x1234 and a 1-cycle oFreqUpdate[1]; STATUS reads 0x2. iFreqAck[1] pulse -> STATUS reads 0x0.
- FREQ write to ch0 with ENABLE=0 -> register updates, no oFreqUpdate pulse, PENDING stays 0. FREQ write coinciding with iFreqAck -> PENDING=1.
- Write ch0 PHASE=0xFFFFFFF5 with PHASE_W=4 -> oPhaseUpdate[ch0]=4'h5 and a 1-cycle oPhaseLatch[0]. Read PHASE with iPhase=4'hA -> 0x0000000A.
- Set IRQ_EN on ch1, raise iStop[1] -> STOP_EVENT set, oIrq=1 one cycle later. Write STATUS=0x4 -> oIrq=0. Repeat with an edge in the same cycle as the clear -> bit stays set.
- NUM_CH=3, CH_AW=2: read address {3,2'b00} -> 0xFFFFFFFF, resp 11. A write there changes no register. iReset_n low for one cycle during a pending update -> PENDING=0 and no strobe.

Source files
------------

// File: rtl/mbldcm_pkg.sv
// -----------------------------------------------------------------------------
// mbldcm_pkg
// Shared definitions for the multi-channel mBldcm Avalon-MM register file:
// per-channel word offsets, read response codes, CTRL/STATUS bit positions
// and the data word returned for reads of a channel that does not exist.
// -----------------------------------------------------------------------------
package mbldcm_pkg;

  // Word offset inside one channel's 4-word window.
  typedef enum logic [1:0] {
    WORD_FREQ   = 2'd0,
    WORD_PHASE  = 2'd1,
    WORD_CTRL   = 2'd2,
    WORD_STATUS = 2'd3
  } word_e;

  // Avalon-MM read response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // CTRL bit positions.
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bit positions.
  localparam int STATUS_STOP_BIT    = 0;
  localparam int STATUS_PENDING_BIT = 1;
  localparam int STATUS_EVENT_BIT   = 2;

  // Read data returned for an address that decodes to no channel.
  localparam logic [31:0] DECERR_DATA = 32'hFFFF_FFFF;

endpackage : mbldcm_pkg

// File: rtl/mbldcm_ch_regs.sv
// -----------------------------------------------------------------------------
// mbldcm_ch_regs
// One motor channel's register bank: frequency target with update strobe and
// UPDATE_PENDING handshake, phase command with latch strobe, CTRL bits, and
// the stop-edge detector feeding the sticky STOP_EVENT bit.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   wr_freq_i            write strobe for the FREQ word of this channel
//   wr_phase_i           write strobe for the PHASE word
//   wr_ctrl_i            write strobe for the CTRL word
//   wr_status_i          write strobe for the STATUS word (W1C on STOP_EVENT)
//   wdata_i              bus write data
//   freq_ack_i           core has adopted the new frequency target
//   stop_i               live motor-stopped level
//   freq_o               registered frequency target
//   freq_update_o        1-cycle strobe: new target issued to the core
//   phase_o              registered phase command
//   phase_latch_o        1-cycle strobe: new phase command issued
//   enable_o, irq_en_o   CTRL.ENABLE and CTRL.IRQ_EN
//   pending_o            UPDATE_PENDING
//   stop_event_o         STOP_EVENT (sticky)
// -----------------------------------------------------------------------------
module mbldcm_ch_regs
  import mbldcm_pkg::*;
#(
  parameter int unsigned FREQ_W  = 32,
  parameter int unsigned PHASE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_freq_i,
  input  logic               wr_phase_i,
  input  logic               wr_ctrl_i,
  input  logic               wr_status_i,
  input  logic [31:0]        wdata_i,
  input  logic               freq_ack_i,
  input  logic               stop_i,
  output logic [FREQ_W-1:0]  freq_o,
  output logic               freq_update_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               phase_latch_o,
  output logic               enable_o,
  output logic               irq_en_o,
  output logic               pending_o,
  output logic               stop_event_o
);

  logic [FREQ_W-1:0]  freq_q,        freq_d;
  logic               freq_upd_q,    freq_upd_d;
  logic [PHASE_W-1:0] phase_q,       phase_d;
  logic               phase_latch_q, phase_latch_d;
  logic               enable_q,      enable_d;
  logic               irq_en_q,      irq_en_d;
  logic               pending_q,     pending_d;
  logic               stop_q,        stop_d;
  logic               event_q,       event_d;

  // Only some write-data bits land in this channel's registers.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    freq_d        = freq_q;
    freq_upd_d    = 1'b0;
    phase_d       = phase_q;
    phase_latch_d = 1'b0;
    enable_d      = enable_q;
    irq_en_d      = irq_en_q;
    pending_d     = pending_q;
    stop_d        = stop_i;
    event_d       = event_q;

    // The strobe is gated by the ENABLE value in force when the write lands;
    // a later 0->1 on ENABLE never replays an earlier write.
    if (wr_freq_i) begin
      freq_d     = wdata_i[FREQ_W-1:0];
      freq_upd_d = enable_q;
    end

    // Acknowledge clears, a fresh strobe sets; the set is applied last so a
    // simultaneous ack loses.
    if (freq_ack_i) pending_d = 1'b0;
    if (wr_freq_i && enable_q) pending_d = 1'b1;

    if (wr_phase_i) begin
      phase_d       = wdata_i[PHASE_W-1:0];
      phase_latch_d = 1'b1;
    end

    if (wr_ctrl_i) begin
      enable_d = wdata_i[CTRL_ENABLE_BIT];
      irq_en_d = wdata_i[CTRL_IRQ_EN_BIT];
    end

    // W1C first, rising stop edge second: an edge coinciding with a clear
    // keeps the event visible.
    if (wr_status_i && wdata_i[STATUS_EVENT_BIT]) event_d = 1'b0;
    if (stop_i && !stop_q) event_d = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      freq_q        <= '0;
      freq_upd_q    <= 1'b0;
      phase_q       <= '0;
      phase_latch_q <= 1'b0;
      enable_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      pending_q     <= 1'b0;
      // Treat the motor as stopped out of reset so a stop level that is
      // already high when reset releases is not mistaken for a new event.
      stop_q        <= 1'b1;
      event_q       <= 1'b0;
    end else begin
      freq_q        <= freq_d;
      freq_upd_q    <= freq_upd_d;
      phase_q       <= phase_d;
      phase_latch_q <= phase_latch_d;
      enable_q      <= enable_d;
      irq_en_q      <= irq_en_d;
      pending_q     <= pending_d;
      stop_q        <= stop_d;
      event_q       <= event_d;
    end
  end

  assign freq_o        = freq_q;
  assign freq_update_o = freq_upd_q;
  assign phase_o       = phase_q;
  assign phase_latch_o = phase_latch_q;
  assign enable_o      = enable_q;
  assign irq_en_o      = irq_en_q;
  assign pending_o     = pending_q;
  assign stop_event_o  = event_q;

endmodule : mbldcm_ch_regs

// File: rtl/mbldcm_avmm_regfile.sv
// -----------------------------------------------------------------------------
// mbldcm_avmm_regfile
// Avalon-MM slave giving NUM_CH mBldcm motor cores a 4-word register bank
// each (FREQ, PHASE, CTRL, STATUS). Reads have a fixed 1-cycle latency with a
// readdatavalid strobe; unmapped channels answer DECODEERROR. One registered
// level interrupt is formed from the per-channel STOP_EVENT & IRQ_EN.
//
// Ports:
//   iClock, iReset_n   clock, synchronous active-low reset
//   iAddr              word address {channel, word[1:0]}
//   iRead, iWrite      single-cycle bus strobes
//   iWdata             write data
//   oRdata, oResp      registered read data / response, held until next read
//   oReadDataValid     1-cycle strobe, one cycle after iRead
//   oIrq               level interrupt
//   iFreqAck           per-channel frequency-adopted pulse
//   iStop              per-channel motor-stopped level
//   iPhase             per-channel live phase vectors
//   oFreqTarget        per-channel frequency targets
//   oFreqUpdate        per-channel target update strobes
//   oPhaseUpdate       per-channel phase commands
//   oPhaseLatch        per-channel phase latch strobes
// -----------------------------------------------------------------------------
module mbldcm_avmm_regfile
  import mbldcm_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CH_AW   = 1,
  parameter int unsigned FREQ_W  = 32,
  parameter int unsigned PHASE_W = 4
) (
  input  logic                        iClock,
  input  logic                        iReset_n,
  input  logic [CH_AW+1:0]            iAddr,
  input  logic                        iRead,
  input  logic                        iWrite,
  input  logic [31:0]                 iWdata,
  output logic [31:0]                 oRdata,
  output logic                        oReadDataValid,
  output logic [1:0]                  oResp,
  output logic                        oIrq,
  input  logic [NUM_CH-1:0]           iFreqAck,
  input  logic [NUM_CH-1:0]           iStop,
  input  logic [NUM_CH*PHASE_W-1:0]   iPhase,
  output logic [NUM_CH*FREQ_W-1:0]    oFreqTarget,
  output logic [NUM_CH-1:0]           oFreqUpdate,
  output logic [NUM_CH*PHASE_W-1:0]   oPhaseUpdate,
  output logic [NUM_CH-1:0]           oPhaseLatch
);

  logic [CH_AW-1:0] ch_sel;
  word_e            word;

  assign ch_sel = iAddr[CH_AW+1:2];
  assign word   = word_e'(iAddr[1:0]);

  logic [NUM_CH-1:0]        enable_v;
  logic [NUM_CH-1:0]        irq_en_v;
  logic [NUM_CH-1:0]        pending_v;
  logic [NUM_CH-1:0]        event_v;
  logic [NUM_CH-1:0][31:0]  ch_rdata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic        wr_here;
    logic [31:0] rd_word;

    // Channel numbers at or above NUM_CH match no instance, so writes to
    // them fall through without touching any register.
    assign wr_here = iWrite && (ch_sel == CH_AW'(c));

    mbldcm_ch_regs #(
      .FREQ_W  (FREQ_W),
      .PHASE_W (PHASE_W)
    ) u_regs (
      .clk_i         (iClock),
      .rst_ni        (iReset_n),
      .wr_freq_i     (wr_here && (word == WORD_FREQ)),
      .wr_phase_i    (wr_here && (word == WORD_PHASE)),
      .wr_ctrl_i     (wr_here && (word == WORD_CTRL)),
      .wr_status_i   (wr_here && (word == WORD_STATUS)),
      .wdata_i       (iWdata),
      .freq_ack_i    (iFreqAck[c]),
      .stop_i        (iStop[c]),
      .freq_o        (oFreqTarget[c*FREQ_W +: FREQ_W]),
      .freq_update_o (oFreqUpdate[c]),
      .phase_o       (oPhaseUpdate[c*PHASE_W +: PHASE_W]),
      .phase_latch_o (oPhaseLatch[c]),
      .enable_o      (enable_v[c]),
      .irq_en_o      (irq_en_v[c]),
      .pending_o     (pending_v[c]),
      .stop_event_o  (event_v[c])
    );

    // Read word for this channel at the addressed offset. Values come from
    // the registers before any same-cycle write lands, so a simultaneous
    // read returns the pre-write contents.
    always_comb begin
      rd_word = '0;
      case (word)
        WORD_FREQ:   rd_word = 32'(oFreqTarget[c*FREQ_W +: FREQ_W]);
        WORD_PHASE:  rd_word = 32'(iPhase[c*PHASE_W +: PHASE_W]);
        WORD_CTRL: begin
          rd_word[CTRL_ENABLE_BIT] = enable_v[c];
          rd_word[CTRL_IRQ_EN_BIT] = irq_en_v[c];
        end
        WORD_STATUS: begin
          rd_word[STATUS_STOP_BIT]    = iStop[c];
          rd_word[STATUS_PENDING_BIT] = pending_v[c];
          rd_word[STATUS_EVENT_BIT]   = event_v[c];
        end
        default: rd_word = '0;
      endcase
    end

    assign ch_rdata[c] = rd_word;
  end

  // Read mux: start from the decode-error answer and replace it only when a
  // real channel matches.
  logic [31:0] rd_mux;
  logic [1:0]  rd_resp_mux;

  always_comb begin
    rd_mux      = DECERR_DATA;
    rd_resp_mux = RESP_DECERR;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == CH_AW'(c)) begin
        rd_mux      = ch_rdata[c];
        rd_resp_mux = RESP_OKAY;
      end
    end
  end

  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q,  resp_d;
  logic        rvalid_q;
  logic        irq_q,   irq_d;

  always_comb begin
    rdata_d = rdata_q;
    resp_d  = resp_q;
    if (iRead) begin
      rdata_d = rd_mux;
      resp_d  = rd_resp_mux;
    end
    irq_d = |(event_v & irq_en_v);
  end

  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      rvalid_q <= iRead;
      irq_q    <= irq_d;
    end
  end

  assign oRdata         = rdata_q;
  assign oResp          = resp_q;
  assign oReadDataValid = rvalid_q;
  assign oIrq           = irq_q;

endmodule : mbldcm_avmm_regfile

// File: tb/tb_mbldcm_avmm_regfile.sv
// -----------------------------------------------------------------------------
// tb_mbldcm_avmm_regfile
// Self-checking bench for mbldcm_avmm_regfile with three channels in a
// four-channel address space (channel 3 unmapped) and a 24-bit FREQ field.
// A behavioural model tracks the register contents per bus cycle; directed
// scenarios are followed by a randomized run compared against the model.
// -----------------------------------------------------------------------------
module tb_mbldcm_avmm_regfile;

  localparam int NC = 3;
  localparam int AW = 2;
  localparam int FW = 24;
  localparam int PW = 4;

  logic              clk;
  logic              rst_n;
  logic [AW+1:0]     addr;
  logic              rd;
  logic              wr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic [1:0]        resp;
  logic              irq;
  logic [NC-1:0]     ack;
  logic [NC-1:0]     stop_in;
  logic [NC*PW-1:0]  phase_in;
  logic [NC*FW-1:0]  ftarget;
  logic [NC-1:0]     fupd;
  logic [NC*PW-1:0]  pupd;
  logic [NC-1:0]     platch;

  mbldcm_avmm_regfile #(
    .NUM_CH  (NC),
    .CH_AW   (AW),
    .FREQ_W  (FW),
    .PHASE_W (PW)
  ) dut (
    .iClock         (clk),
    .iReset_n       (rst_n),
    .iAddr          (addr),
    .iRead          (rd),
    .iWrite         (wr),
    .iWdata         (wdata),
    .oRdata         (rdata),
    .oReadDataValid (rvalid),
    .oResp          (resp),
    .oIrq           (irq),
    .iFreqAck       (ack),
    .iStop          (stop_in),
    .iPhase         (phase_in),
    .oFreqTarget    (ftarget),
    .oFreqUpdate    (fupd),
    .oPhaseUpdate   (pupd),
    .oPhaseLatch    (platch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  logic [FW-1:0] m_freq [NC];
  logic [PW-1:0] m_phase[NC];
  logic [NC-1:0] m_en, m_irqen, m_pend, m_evt, m_stop_prev;
  logic [31:0]   e_rdata;
  logic [1:0]    e_resp;
  logic          e_rvalid, e_irq;
  logic [NC-1:0] e_fupd, e_platch;

  function automatic logic [AW+1:0] mk(input int ch, input int w);
    return (AW+2)'((ch << 2) | w);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_freq[c]  = '0;
      m_phase[c] = '0;
    end
    m_en = '0; m_irqen = '0; m_pend = '0; m_evt = '0;
    m_stop_prev = '1;
    e_rdata = '0; e_resp = 2'b00; e_rvalid = 1'b0; e_irq = 1'b0;
    e_fupd = '0; e_platch = '0;
  endtask

  // Apply the current inputs to the model, then advance one clock and
  // settle 1 time unit past the edge.
  task automatic tick();
    int ach;
    int aw;
    logic [NC-1:0] next_evt;
    ach = int'(addr[AW+1:2]);
    aw  = int'(addr[1:0]);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (rd) begin
        if (ach >= NC) begin
          e_rdata = 32'hFFFF_FFFF;
          e_resp  = 2'b11;
        end else begin
          e_resp = 2'b00;
          case (aw)
            0: e_rdata = 32'(m_freq[ach]);
            1: e_rdata = 32'(phase_in[ach*PW +: PW]);
            2: e_rdata = {30'd0, m_irqen[ach], m_en[ach]};
            default: e_rdata = {29'd0, m_evt[ach], m_pend[ach], stop_in[ach]};
          endcase
        end
      end
      e_rvalid = rd;
      e_irq    = |(m_evt & m_irqen);
      e_fupd   = '0;
      e_platch = '0;
      next_evt = m_evt;
      for (int c = 0; c < NC; c++) begin
        if (wr && ach == c && aw == 3 && wdata[2]) next_evt[c] = 1'b0;
        if (stop_in[c] && !m_stop_prev[c]) next_evt[c] = 1'b1;
        if (ack[c]) m_pend[c] = 1'b0;
        if (wr && ach == c) begin
          case (aw)
            0: begin
              m_freq[c] = wdata[FW-1:0];
              if (m_en[c]) begin
                e_fupd[c] = 1'b1;
                m_pend[c] = 1'b1;
              end
            end
            1: begin
              m_phase[c]  = wdata[PW-1:0];
              e_platch[c] = 1'b1;
            end
            2: begin
              m_en[c]    = wdata[0];
              m_irqen[c] = wdata[1];
            end
            default: ;
          endcase
        end
      end
      m_evt       = next_evt;
      m_stop_prev = stop_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int w, input logic [31:0] d);
    wr = 1'b1; addr = mk(ch, w); wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic do_read(input int ch, input int w);
    rd = 1'b1; addr = mk(ch, w);
    tick();
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_chk++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b exp 0", rvalid); end
    n_chk++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b exp 0", irq); end
    n_chk++; if ({fupd, platch} !== '0) begin n_err++; $display("FAIL rst_strobes: got %b exp 0", {fupd, platch}); end
    n_chk++; if ({ftarget, pupd} !== '0) begin n_err++; $display("FAIL rst_targets: got %h exp 0", {ftarget, pupd}); end
    do_read(0, 3);
    n_chk++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL rd0_valid: got %b exp 1", rvalid); end
    n_chk++; if (rdata !== 32'h0 || resp !== 2'b00) begin n_err++; $display("FAIL rd0_status: got %h/%b exp 0/00", rdata, resp); end
    tick();
    n_chk++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rd0_valid_drop: got %b exp 0", rvalid); end
    do_read(1, 3);
    n_chk++; if (rvalid !== 1'b1 || rdata !== 32'h0 || resp !== 2'b00) begin
      n_err++; $display("FAIL rd1_status: got v=%b %h/%b exp v=1 0/00", rvalid, rdata, resp); end
  endtask

  task automatic test_freq_handshake();
    do_write(1, 2, 32'h1);
    do_write(1, 0, 32'h0000_1234);
    n_chk++; if (ftarget[1*FW +: FW] !== 24'h1234) begin n_err++; $display("FAIL hs_target: got %h exp 001234", ftarget[1*FW +: FW]); end
    n_chk++; if (fupd !== 3'b010) begin n_err++; $display("FAIL hs_strobe: got %b exp 010", fupd); end
    do_read(1, 3);
    n_chk++; if (fupd !== 3'b000) begin n_err++; $display("FAIL hs_strobe_width: got %b exp 000", fupd); end
    n_chk++; if (rdata !== 32'h2) begin n_err++; $display("FAIL hs_pending: got %h exp 2", rdata); end
    ack = 3'b010; tick(); ack = '0;
    do_read(1, 3);
    n_chk++; if (rdata !== 32'h0) begin n_err++; $display("FAIL hs_ack_clear: got %h exp 0", rdata); end
  endtask

  task automatic test_freq_disabled();
    do_write(0, 0, 32'hABCD_EF12);
    n_chk++; if (ftarget[FW-1:0] !== 24'hCDEF12) begin n_err++; $display("FAIL dis_target: got %h exp cdef12", ftarget[FW-1:0]); end
    n_chk++; if (fupd !== 3'b000) begin n_err++; $display("FAIL dis_no_strobe: got %b exp 000", fupd); end
    do_read(0, 0);
    n_chk++; if (rdata !== 32'h00CD_EF12) begin n_err++; $display("FAIL dis_readback: got %h exp 00cdef12", rdata); end
    do_read(0, 3);
    n_chk++; if (rdata !== 32'h0) begin n_err++; $display("FAIL dis_pending: got %h exp 0", rdata); end
    do_write(0, 2, 32'h1);
    tick();
    n_chk++; if (fupd !== 3'b000) begin n_err++; $display("FAIL dis_no_retro: got %b exp 000", fupd); end
    ack = 3'b001;
    do_write(0, 0, 32'h0000_0042);
    ack = '0;
    n_chk++; if (fupd !== 3'b001) begin n_err++; $display("FAIL ack_collide_strobe: got %b exp 001", fupd); end
    do_read(0, 3);
    n_chk++; if (rdata !== 32'h2) begin n_err++; $display("FAIL ack_collide_set_wins: got %h exp 2", rdata); end
    ack = 3'b001; tick(); ack = '0;
  endtask

  task automatic test_phase();
    do_write(0, 1, 32'hFFFF_FFF5);
    n_chk++; if (pupd[PW-1:0] !== 4'h5) begin n_err++; $display("FAIL ph_cmd: got %h exp 5", pupd[PW-1:0]); end
    n_chk++; if (platch !== 3'b001) begin n_err++; $display("FAIL ph_latch: got %b exp 001", platch); end
    phase_in[PW-1:0] = 4'hA;
    do_read(0, 1);
    n_chk++; if (platch !== 3'b000) begin n_err++; $display("FAIL ph_latch_width: got %b exp 000", platch); end
    n_chk++; if (rdata !== 32'h0000_000A) begin n_err++; $display("FAIL ph_live: got %h exp 0000000a", rdata); end
  endtask

  task automatic test_irq();
    do_write(1, 2, 32'h3);
    stop_in[1] = 1'b1;
    tick();
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b exp 0", irq); end
    do_read(1, 3);
    n_chk++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b exp 1", irq); end
    n_chk++; if (rdata !== 32'h5) begin n_err++; $display("FAIL irq_status: got %h exp 5", rdata); end
    do_write(1, 3, 32'h4);
    tick();
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c: got %b exp 0", irq); end
    stop_in[1] = 1'b0;
    tick();
    stop_in[1] = 1'b1;
    do_write(1, 3, 32'h4);
    do_read(1, 3);
    n_chk++; if (rdata !== 32'h5) begin n_err++; $display("FAIL irq_edge_vs_clear: got %h exp 5", rdata); end
    n_chk++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_edge_vs_clear_irq: got %b exp 1", irq); end
    do_write(1, 3, 32'h4);
    stop_in[1] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_write(1, 0, 32'h111);
    n_chk++; if (fupd !== 3'b010 || ftarget[1*FW +: FW] !== 24'h111) begin
      n_err++; $display("FAIL b2b_first: got %b/%h exp 010/000111", fupd, ftarget[1*FW +: FW]); end
    do_write(1, 0, 32'h222);
    n_chk++; if (fupd !== 3'b010 || ftarget[1*FW +: FW] !== 24'h222) begin
      n_err++; $display("FAIL b2b_second: got %b/%h exp 010/000222", fupd, ftarget[1*FW +: FW]); end
    rd = 1'b1;
    do_write(1, 0, 32'h333);
    rd = 1'b0;
    n_chk++; if (rdata !== 32'h222) begin n_err++; $display("FAIL rw_same_cycle: got %h exp 00000222", rdata); end
    n_chk++; if (ftarget[1*FW +: FW] !== 24'h333) begin n_err++; $display("FAIL rw_write_lands: got %h exp 000333", ftarget[1*FW +: FW]); end
    ack = 3'b010; tick(); ack = '0;
  endtask

  task automatic test_invalid();
    do_read(3, 0);
    n_chk++; if (rdata !== 32'hFFFF_FFFF || resp !== 2'b11) begin
      n_err++; $display("FAIL decerr: got %h/%b exp ffffffff/11", rdata, resp); end
    for (int w = 0; w < 4; w++) do_write(3, w, $urandom);
    n_chk++; if ({fupd, platch} !== '0) begin n_err++; $display("FAIL decerr_no_strobe: got %b exp 0", {fupd, platch}); end
    for (int c = 0; c < NC; c++) begin
      for (int w = 0; w < 4; w++) begin
        do_read(c, w);
        n_chk++; if (rdata !== e_rdata || resp !== 2'b00) begin
          n_err++; $display("FAIL decerr_untouched ch%0d w%0d: got %h/%b exp %h/00", c, w, rdata, resp, e_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(2, 2, 32'h1);
    do_write(2, 0, 32'h55);
    stop_in[2] = 1'b1;
    rst_n = 1'b0;
    do_write(2, 0, 32'h66);
    n_chk++; if (fupd !== 3'b000 || ftarget !== '0) begin
      n_err++; $display("FAIL midrst_strobe: got %b/%h exp 000/0", fupd, ftarget); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (fupd !== 3'b000) begin n_err++; $display("FAIL midrst_no_late_strobe: got %b exp 000", fupd); end
    do_read(2, 3);
    n_chk++; if (rdata !== 32'h1) begin n_err++; $display("FAIL midrst_status: got %h exp 1", rdata); end
    stop_in[2] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 149) != 0);
      rd       = ($urandom_range(0, 2) == 0);
      wr       = ($urandom_range(0, 1) == 0);
      addr     = (AW+2)'($urandom);
      wdata    = $urandom;
      ack      = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
      if ($urandom_range(0, 7) == 0) stop_in[$urandom_range(0, NC-1)] ^= 1'b1;
      phase_in = (NC*PW)'($urandom);
      tick();
      n_chk++; if (rvalid !== e_rvalid) begin n_err++; $display("FAIL rnd_rvalid @%0d: got %b exp %b", i, rvalid, e_rvalid); end
      n_chk++; if (rdata !== e_rdata || resp !== e_resp) begin
        n_err++; $display("FAIL rnd_rdata @%0d: got %h/%b exp %h/%b", i, rdata, resp, e_rdata, e_resp); end
      n_chk++; if (fupd !== e_fupd || platch !== e_platch) begin
        n_err++; $display("FAIL rnd_strobes @%0d: got %b/%b exp %b/%b", i, fupd, platch, e_fupd, e_platch); end
      n_chk++; if (irq !== e_irq) begin n_err++; $display("FAIL rnd_irq @%0d: got %b exp %b", i, irq, e_irq); end
      for (int c = 0; c < NC; c++) begin
        n_chk++; if (ftarget[c*FW +: FW] !== m_freq[c] || pupd[c*PW +: PW] !== m_phase[c]) begin
          n_err++; $display("FAIL rnd_targets @%0d ch%0d: got %h/%h exp %h/%h", i, c,
                            ftarget[c*FW +: FW], pupd[c*PW +: PW], m_freq[c], m_phase[c]); end
      end
    end
    rst_n = 1'b1; rd = 1'b0; wr = 1'b0; ack = '0;
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    ack = '0; stop_in = '0; phase_in = '0;
    model_reset();
    test_reset();
    test_freq_handshake();
    test_freq_disabled();
    test_phase();
    test_irq();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mbldcm_avmm_regfile
